shape_cmd_fifo: RTL and testbench

- Downstream stage of the UART programming receiver.
- Captures each 36-bit programming command (shape address, register address, data) on the receiver's one-cycle program strobe.
- Buffers commands in a first-word-fall-through FIFO and presents them to the shape register bank / renderer over a valid/ready handshake.
- Decouples the bursty UART command stream from render-side stalls and reports lost commands.

---
 rtl/shape_cmd_fifo.sv | 114 +++++++++++
 tb/tb_shape_cmd_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shape_cmd_fifo.sv
// FWFT command FIFO behind the UART programming receiver; strobe-to-valid latency 1 cycle. Optional shape range check: SHAPE_CMD_RANGE_CHECK_EN.
// Backpressure: cmd_ready stalls the head; strobes that arrive while full (no pop) are dropped and set sticky overflow.
module shape_cmd_fifo #(
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 4,
  parameter int NUM_SHAPES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             program_in,
  input  logic [11:0]      shape_addr_in,
  input  logic [11:0]      reg_addr_in,
  input  logic [11:0]      data_in,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [11:0]      cmd_shape_addr,
  output logic [11:0]      cmd_reg_addr,
  output logic [11:0]      cmd_data,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  input  logic             clear_overflow,
  output logic             range_err
);

  typedef struct packed {
    logic [11:0] data;
    logic [11:0] reg_addr;
    logic [11:0] shape_addr;
  } cmd_t;

  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = 1;
  localparam logic [12:0]      SHAPE_LIM = 13'(NUM_SHAPES);

  cmd_t             mem [DEPTH];
  cmd_t             wr_dat;
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt_q;
  logic             ovf_q;
  logic             rerr_q;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop_full;
  logic             in_range;
  logic             range_reject;

`ifdef SHAPE_CMD_RANGE_CHECK_EN
  assign in_range     = ({1'b0, shape_addr_in} < SHAPE_LIM);
  assign range_reject = program_in & ~in_range;
`else
  logic [12:0] shape_lim_unused;
  assign shape_lim_unused = SHAPE_LIM;
  assign in_range         = 1'b1;
  assign range_reject     = 1'b0;
`endif

  assign full      = (cnt_q == FULL_CNT);
  assign pop       = cmd_valid & cmd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = program_in & in_range & (~full | pop);
  assign drop_full = program_in & in_range & full & ~pop;

  assign wr_dat.data       = data_in;
  assign wr_dat.reg_addr   = reg_addr_in;
  assign wr_dat.shape_addr = shape_addr_in;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      rerr_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
      if (drop_full) begin
        ovf_q <= 1'b1;
      end else if (clear_overflow) begin
        ovf_q <= 1'b0;
      end
      rerr_q <= range_reject;
    end
  end

  assign head           = mem[rd_ptr];
  assign cmd_valid      = (cnt_q != '0);
  assign cmd_shape_addr = head.shape_addr;
  assign cmd_reg_addr   = head.reg_addr;
  assign cmd_data       = head.data;
  assign count          = cnt_q;
  assign overflow       = ovf_q;
  assign range_err      = rerr_q;

endmodule

// File: tb/tb_shape_cmd_fifo.sv
// Bench for shape_cmd_fifo: vector table, directed corner sequences and a queue-based random scoreboard.
module tb_shape_cmd_fifo;

  localparam int DEPTH = 16;
`ifdef SHAPE_CMD_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        program_in;
  logic [11:0] shape_addr_in;
  logic [11:0] reg_addr_in;
  logic [11:0] data_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_shape_addr;
  logic [11:0] cmd_reg_addr;
  logic [11:0] cmd_data;
  logic [4:0]  count;
  logic        overflow;
  logic        clear_overflow;
  logic        range_err;

  int passed = 0;
  int total  = 0;

  logic [35:0] mq[$];
  bit          m_ovf;
  bit          m_rerr;

  shape_cmd_fifo #(.DEPTH(16), .PTR_W(4), .NUM_SHAPES(64)) dut (
    .clk(clk), .rst_n(rst_n), .program_in(program_in),
    .shape_addr_in(shape_addr_in), .reg_addr_in(reg_addr_in), .data_in(data_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shape_addr(cmd_shape_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
    .count(count), .overflow(overflow), .clear_overflow(clear_overflow), .range_err(range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  typedef struct {
    bit          p;
    logic [11:0] s, r, d;
    bit          rdy;
    int          ecnt;
    bit          evld;
    logic [35:0] ehead;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d, required %0d", name, act, exp);
    else passed++;
  endtask

  task automatic chk_h(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %09h, required %09h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [35:0] head_now();
    return {cmd_data, cmd_reg_addr, cmd_shape_addr};
  endfunction

  task automatic drive(input bit p, input logic [11:0] s, input logic [11:0] r,
                       input logic [11:0] d, input bit rdy, input bit clr);
    program_in     = p;
    shape_addr_in  = s;
    reg_addr_in    = r;
    data_in        = d;
    cmd_ready      = rdy;
    clear_overflow = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit p, input logic [11:0] s, input logic [11:0] d,
                     input bit rdy, input bit clr);
    drive(p, s, 12'h000, d, rdy, clr);
    step();
  endtask

  task automatic do_reset();
    drive(1'b0, 12'h0, 12'h0, 12'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ovf  = 1'b0;
    m_rerr = 1'b0;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) cyc(1'b1, 12'h001, 12'(base + i), 1'b0, 1'b0);
  endtask

  task automatic drain_quiet();
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 12'h0, 12'h0, 1'b1, 1'b0);
  endtask

  // Reference: a queue of stored commands and the occupancy rules applied in one shot.
  task automatic model_tick(input bit p, input logic [11:0] s, input logic [11:0] r,
                            input logic [11:0] d, input bit rdy, input bit clr);
    bit ok, mpop, mpush, mdrop;
    ok    = !RC || (s < 12'd64);
    mpop  = (mq.size() != 0) && rdy;
    mpush = p && ok && ((mq.size() < DEPTH) || mpop);
    mdrop = p && ok && (mq.size() == DEPTH) && !mpop;
    if (mpop) void'(mq.pop_front());
    if (mpush) mq.push_back({d, r, s});
    if (mdrop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_rerr = p && !ok;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 12'h0, 12'h0, 12'h0, 1'b0, 1'b0);
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_valid", int'(cmd_valid), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_range_err", int'(range_err), 0);
    do_reset();

    vecs[0] = '{1'b1, 12'h003, 12'h00A, 12'hABC, 1'b0, 1, 1'b1, {12'hABC, 12'h00A, 12'h003}};
    vecs[1] = '{1'b0, 12'h000, 12'h000, 12'h000, 1'b0, 1, 1'b1, {12'hABC, 12'h00A, 12'h003}};
    vecs[2] = '{1'b0, 12'h000, 12'h000, 12'h000, 1'b1, 0, 1'b0, 36'h0};
    vecs[3] = '{1'b1, 12'h03F, 12'h001, 12'h111, 1'b0, 1, 1'b1, {12'h111, 12'h001, 12'h03F}};
    vecs[4] = '{1'b1, 12'h005, 12'h002, 12'h222, 1'b1, 1, 1'b1, {12'h222, 12'h002, 12'h005}};
    vecs[5] = '{1'b1, 12'h006, 12'h003, 12'h333, 1'b0, 2, 1'b1, {12'h222, 12'h002, 12'h005}};
    vecs[6] = '{1'b0, 12'h000, 12'h000, 12'h000, 1'b1, 1, 1'b1, {12'h333, 12'h003, 12'h006}};
    vecs[7] = '{1'b0, 12'h000, 12'h000, 12'h000, 1'b1, 0, 1'b0, 36'h0};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].p, vecs[i].s, vecs[i].r, vecs[i].d, vecs[i].rdy, 1'b0);
      step();
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].ecnt);
      chk($sformatf("vec%0d_valid", i), int'(cmd_valid), int'(vecs[i].evld));
      chk($sformatf("vec%0d_overflow", i), int'(overflow), 0);
      if (vecs[i].evld) chk_h($sformatf("vec%0d_head", i), head_now(), vecs[i].ehead);
    end

    // Fill past full: 17th strobe is lost.
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 12'(i), 12'(i), 1'b0, 1'b0);
      if (i == 15) begin
        chk("fill_count16", int'(count), 16);
        chk("fill_no_overflow_yet", int'(overflow), 0);
      end
    end
    chk("overflow_count", int'(count), 16);
    chk("overflow_set", int'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_valid%0d", i), int'(cmd_valid), 1);
      chk($sformatf("drain_data%0d", i), int'(cmd_data), i);
      cyc(1'b0, 12'h0, 12'h0, 1'b1, 1'b0);
    end
    chk("drain_empty_count", int'(count), 0);
    chk("drain_empty_valid", int'(cmd_valid), 0);

    // Simultaneous push and pop at full.
    cyc(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
    chk("clear_overflow", int'(overflow), 0);
    fill(16, 12'h100);
    chk("refill_count", int'(count), 16);
    cyc(1'b1, 12'h002, 12'h5A5, 1'b1, 1'b0);
    chk("pushpop_full_count", int'(count), 16);
    chk("pushpop_full_overflow", int'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("pp_drain_data%0d", i), int'(cmd_data), (i == 15) ? 12'h5A5 : 12'h101 + i);
      cyc(1'b0, 12'h0, 12'h0, 1'b1, 1'b0);
    end
    chk("pp_drain_empty", int'(cmd_valid), 0);

    // Set beats clear.
    fill(16, 12'h200);
    cyc(1'b1, 12'h001, 12'h7FF, 1'b0, 1'b1);
    chk("set_beats_clear", int'(overflow), 1);
    chk("set_beats_clear_count", int'(count), 16);
    cyc(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
    chk("clear_alone", int'(overflow), 0);
    drain_quiet();
    chk("sbc_drain_empty", int'(count), 0);

    // Range check boundary.
    if (RC) begin
      cyc(1'b1, 12'h040, 12'h321, 1'b0, 1'b0);
      chk("range_reject_pulse", int'(range_err), 1);
      chk("range_reject_count", int'(count), 0);
      cyc(1'b0, 12'h0, 12'h0, 1'b0, 1'b0);
      chk("range_pulse_ends", int'(range_err), 0);
      cyc(1'b1, 12'h03F, 12'h322, 1'b0, 1'b0);
      chk("range_accept_count", int'(count), 1);
      chk("range_accept_rerr", int'(range_err), 0);
      chk_h("range_accept_head", head_now(), {12'h322, 12'h000, 12'h03F});
      fill(15, 12'h300);
      cyc(1'b1, 12'h040, 12'h323, 1'b0, 1'b0);
      chk("range_full_rerr", int'(range_err), 1);
      chk("range_full_overflow", int'(overflow), 0);
      chk("range_full_count", int'(count), 16);
    end else begin
      cyc(1'b1, 12'h040, 12'h321, 1'b0, 1'b0);
      chk("norange_count", int'(count), 1);
      chk("norange_rerr", int'(range_err), 0);
      chk_h("norange_head", head_now(), {12'h321, 12'h000, 12'h040});
    end
    drain_quiet();

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int bias;
      bit p, rdy, clr;
      logic [11:0] s, r, d;
      bias = (((i / 50) % 3) == 0) ? 85 : (((i / 50) % 3) == 1) ? 50 : 15;
      p    = ($urandom_range(0, 99) < bias);
      rdy  = ($urandom_range(0, 99) >= bias);
      clr  = ($urandom_range(0, 19) == 0);
      s    = 12'($urandom_range(0, 79));
      r    = 12'($urandom);
      d    = 12'($urandom);
      model_tick(p, s, r, d, rdy, clr);
      drive(p, s, r, d, rdy, clr);
      step();
      chk($sformatf("rnd%0d_count", i), int'(count), mq.size());
      chk($sformatf("rnd%0d_valid", i), int'(cmd_valid), int'(mq.size() != 0));
      chk($sformatf("rnd%0d_overflow", i), int'(overflow), int'(m_ovf));
      chk($sformatf("rnd%0d_range_err", i), int'(range_err), int'(m_rerr));
      chk($sformatf("rnd%0d_count_le_depth", i), int'(count <= 5'd16), 1);
      if (mq.size() != 0) chk_h($sformatf("rnd%0d_head", i), head_now(), mq[0]);
    end

    // Asynchronous reset mid-drain.
    do_reset();
    fill(17, 12'h400);
    for (int i = 0; i < 11; i++) cyc(1'b0, 12'h0, 12'h0, 1'b1, 1'b0);
    chk("pre_reset_count", int'(count), 5);
    chk("pre_reset_overflow", int'(overflow), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_valid", int'(cmd_valid), 0);
    chk("async_reset_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 12'h009, 12'h0AA, 1'b0, 1'b0);
    chk("post_reset_push_count", int'(count), 1);
    chk("post_reset_push_data", int'(cmd_data), 12'h0AA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
